vector_sweep_capture: RTL and testbench
=======================================

# vector_sweep_capture

Synthesizable stimulus/response stage for a combinational or sequential device under test (DUT). On `start`, it walks the DUT inputs exhaustively from 0 to 2^N_IN−1 and waits a programmable settle time after each vector. It then samples the DUT output and emits one `{vector, response}` record per vector on a valid/ready stream to the downstream logger. It is the on-chip equivalent of the exhaustive sweep-and-record step used for trojan-detection data collection.

## Interface
- `N_IN`, 3, DUT input width; legal 1..16.
- `N_OUT`, 1, DUT output width; legal 1..16.
- `SETTLE`, 1, cycles between driving a vector and sampling `dut_out`; legal 1..255.
- `CK  input  1`: clock; all flops rising-edge.
- `reset  input  1`: asynchronous, active-low reset.
- `start  input  1`: begin sweep; sampled only in IDLE.
- `abort  input  1`: cancel sweep; sampled in every non-IDLE state.
- `busy  output  1`: high in every state except IDLE.
- `done  output  1`: one-cycle pulse after the last record is accepted.
- `dut_in  output  N_IN`: registered vector driven to the DUT.
- `dut_out  input  N_OUT`: DUT response.
- `rec_valid  output  1`: record available.
- `rec_ready  input  1`: downstream accepts.
- `rec_data  output  N_IN+N_OUT`: {vector, response}, vector in MSBs.
- `signature  output  16`: response signature; see Configuration.

## Operation
- States: IDLE, SETTLE, EMIT, DONE.
- IDLE:
  - `start`=1 → SETTLE.
  - `vec`←0, `dut_in`←0, settle counter←SETTLE−1, signature←16'hFFFF.
- SETTLE:
  - Settle counter decrements.
  - At 0: capture `rec_data`←{vec, dut_out}, set `rec_valid`←1 → EMIT.
- EMIT:
  - `rec_valid` and `rec_data` are held stable until `rec_valid && rec_ready`.
  - On handshake with `vec`==all-ones → DONE, `rec_valid`←0.
  - On handshake otherwise: `vec`←vec+1, `dut_in`←vec+1, counter←SETTLE−1, `rec_valid`←0 → SETTLE.
- DONE: `done`=1 for one cycle; `dut_in`←0 → IDLE.
- `abort`=1 in SETTLE, EMIT, or DONE → IDLE next edge.
  - `rec_valid`, `done`, and `dut_in` return to 0.
  - No `done` pulse; the signature is frozen.
- `start` while busy is ignored. Simultaneous `start` and `abort` in IDLE: `start` wins, because `abort` is not sampled in IDLE.
- `vec` is N_IN bits wide. The wrap from all-ones never occurs; the sweep terminates there.
- Exactly 2^N_IN records are emitted per unaborted sweep, in ascending order.

## Timing
- Reset values: state IDLE.
  - `busy`, `done`, `rec_valid` = 0.
  - `dut_in`, `rec_data` = 0.
  - `signature` = 16'h0000.
- Reset asserted mid-sweep clears everything asynchronously. No record or `done` follows.
- `start` sampled at edge k: `dut_in`=0 and `busy`=1 from k. `dut_out` is sampled at edge k+SETTLE. `rec_valid`=1 from k+SETTLE.
- Handshake at edge h: next `dut_in` from h, next `rec_valid` from h+SETTLE.
- Sustained period with `rec_ready`=1: SETTLE+1 cycles per record.
- `done` is high in the cycle following the final handshake.
- `rec_ready` low stalls indefinitely. `dut_in` is unchanged during the stall.

## Configuration
- `VSC_SIGNATURE_EN` defined:
  - `signature` is a 16-bit MISR with polynomial x^16+x^12+x^5+1.
  - It is seeded to 16'hFFFF at start.
  - Each accepted record, zero-extended to 16 bits, is XORed into it after one LFSR shift.
  - Value is valid from the `done` cycle onward and held until the next start or reset.
- Not defined: `signature` is tied to 16'h0000. No MISR flops are present.

## Structure
- Package `vsc_pkg` contains:
  - State enum `vsc_state_t` {IDLE, SETTLE, EMIT, DONE}.
  - `MISR_POLY` = 16'h1021 and `MISR_SEED` = 16'hFFFF.
  - The function that computes record width.
- Sub-module `vsc_misr`:
  - Contains the signature register with clear and enable; its output is 16 bits.
  - Instantiated only under `VSC_SIGNATURE_EN`.

## Test plan
- Basic sweep: N_IN=3, N_OUT=1, SETTLE=1, DUT = 3-input XOR, `rec_ready`=1, `start` pulse.
  - Required: 8 records 0000,0011,0101,0110,1001,1010,1100,1111.
  - Period is 2 cycles; `done` comes one cycle after the last record.
- Backpressure: `rec_ready` low for 5 cycles on record 3.
  - Required: `rec_data`=0110 and `dut_in`=3'b011 are held stable, with no duplicate or lost records.
- Settle: SETTLE=4, DUT is a registered AND, 2 cycles deep.
  - Required: every response equals AND of the vector.
  - First `rec_valid` appears 4 cycles after `start`.
- Abort: assert `abort` during vector 5 SETTLE.
  - Required: IDLE next cycle, `rec_valid`=0, `dut_in`=0, no `done`.
  - A fresh `start` restarts from vector 0.
- Reset mid-EMIT: drop `reset` asynchronously.
  - Required: all outputs 0 immediately.
  - After release, `start` produces a full 8-record sweep.
- Signature (`VSC_SIGNATURE_EN`): XOR-DUT sweep run twice.
  - Required: identical `signature` each time, matching the bench MISR model.
  - Flipping one DUT response changes the signature.

Source files
------------

// File: rtl/vsc_pkg.sv
// Shared types and helpers for vector_sweep_capture: FSM states, MISR
// constants, record width and the MISR next-state function.
package vsc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } vsc_state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  function automatic int rec_width(input int n_in, input int n_out);
    return n_in + n_out;
  endfunction

  // One left shift with feedback on bit 15, then fold in the new record.
  function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                            input logic [15:0] din);
    logic [15:0] shifted;
    shifted = {sig[14:0], 1'b0};
    if (sig[15]) begin
      shifted = shifted ^ MISR_POLY;
    end
    return shifted ^ din;
  endfunction

endpackage

// File: rtl/vsc_misr.sv
// 16-bit response signature register: clear loads the seed, enable folds one
// record in. Only instantiated when VSC_SIGNATURE_EN is defined.
module vsc_misr
  import vsc_pkg::*;
(
  input  logic        CK,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic [15:0] i_data,
  output logic [15:0] o_sig
);

  logic [15:0] r_sig;

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_sig <= 16'h0000;
    end else if (i_clear) begin
      r_sig <= MISR_SEED;
    end else if (i_en) begin
      r_sig <= misr_next(r_sig, i_data);
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/vector_sweep_capture.sv
// Exhaustive DUT input sweep with programmable settle time, streaming one
// {vector, response} record per vector. Optional MISR under VSC_SIGNATURE_EN.
module vector_sweep_capture
  import vsc_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1
) (
  input  logic                                 CK,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  output logic                                 busy,
  output logic                                 done,
  output logic [N_IN-1:0]                      dut_in,
  input  logic [N_OUT-1:0]                     dut_out,
  output logic                                 rec_valid,
  input  logic                                 rec_ready,
  output logic [rec_width(N_IN, N_OUT)-1:0]    rec_data,
  output logic [15:0]                          signature,
  output vsc_state_t                           state_dbg
);

  // Record stream: rec_data is held stable while rec_valid is high and
  // rec_ready is low; a record transfers on the edge where both are high.

  localparam int              REC_W    = rec_width(N_IN, N_OUT);
  localparam logic [7:0]      CNT_INIT = 8'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);

  vsc_state_t       r_state;
  logic [N_IN-1:0]  r_vec;
  logic [N_IN-1:0]  r_dut_in;
  logic [7:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_valid;
  logic [REC_W-1:0] r_rec;

  logic w_hs;
  logic w_sig_clear;
  logic w_sig_en;

  assign w_hs        = r_valid && rec_ready;
  assign w_sig_clear = (r_state == IDLE) && start;
  assign w_sig_en    = (r_state == EMIT) && w_hs && !abort;

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_vec    <= '0;
      r_dut_in <= '0;
      r_cnt    <= 8'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_rec    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_vec    <= '0;
          r_dut_in <= '0;
          r_cnt    <= CNT_INIT;
          r_valid  <= 1'b0;
          r_done   <= 1'b0;
          if (start) begin
            r_state <= vsc_pkg::SETTLE;
            r_busy  <= 1'b1;
          end
        end

        vsc_pkg::SETTLE: begin
          if (abort) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_dut_in <= '0;
          end else if (r_cnt == 8'd0) begin
            r_rec   <= {r_vec, dut_out};
            r_valid <= 1'b1;
            r_state <= EMIT;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        EMIT: begin
          if (abort) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_dut_in <= '0;
          end else if (w_hs) begin
            r_valid <= 1'b0;
            // The sweep ends on the all-ones vector; the counter never wraps.
            if (r_vec == VEC_LAST) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_vec    <= r_vec + VEC_ONE;
              r_dut_in <= r_vec + VEC_ONE;
              r_cnt    <= CNT_INIT;
              r_state  <= vsc_pkg::SETTLE;
            end
          end
        end

        DONE: begin
          // Abort here has the same effect as the normal exit.
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_valid  <= 1'b0;
          r_dut_in <= '0;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign dut_in    = r_dut_in;
  assign rec_valid = r_valid;
  assign rec_data  = r_rec;
  assign state_dbg = r_state;

`ifdef VSC_SIGNATURE_EN
  // Records wider than 16 bits are folded so every bit reaches the MISR.
  logic [31:0] w_rec_ext;
  logic [15:0] w_sig_data;

  assign w_rec_ext  = 32'(r_rec);
  assign w_sig_data = w_rec_ext[15:0] ^ w_rec_ext[31:16];

  vsc_misr u_misr (
    .CK      (CK),
    .reset   (reset),
    .i_clear (w_sig_clear),
    .i_en    (w_sig_en),
    .i_data  (w_sig_data),
    .o_sig   (signature)
  );
`else
  logic w_sig_unused;
  assign w_sig_unused = w_sig_clear | w_sig_en;
  assign signature    = 16'h0000;
`endif

endmodule

// File: tb/tb_vector_sweep_capture.sv
// Bench for vector_sweep_capture: XOR DUT (SETTLE=1) and registered-AND DUT
// (SETTLE=4), expected-record queues with negedge monitors.
`timescale 1ns/1ps
module tb_vector_sweep_capture;

  // ---------------- clock / reset ----------------
  logic CK = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  initial forever #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  // ---------------- DUT A: XOR, SETTLE=1 ----------------
  logic        start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b1;
  logic        busy_a, done_a, valid_a, dut_out_a;
  logic [2:0]  dut_in_a;
  logic [3:0]  data_a;
  logic [15:0] sig_a;
  vsc_pkg::vsc_state_t st_a;
  logic        flip_en = 1'b0;

  assign dut_out_a = (^dut_in_a) ^ (flip_en && (dut_in_a == 3'd5));

  vector_sweep_capture #(.N_IN(3), .N_OUT(1), .SETTLE(1)) u_dut_a (
    .CK(CK), .reset(reset), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
    .rec_valid(valid_a), .rec_ready(ready_a), .rec_data(data_a),
    .signature(sig_a), .state_dbg(st_a)
  );

  // ---------------- DUT B: registered AND 2 deep, SETTLE=4 ----------------
  logic        start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1;
  logic        busy_b, done_b, valid_b, dut_out_b;
  logic [2:0]  dut_in_b;
  logic [3:0]  data_b;
  logic [15:0] sig_b;
  vsc_pkg::vsc_state_t st_b;
  logic        and_p1 = 1'b0, and_p2 = 1'b0;

  always @(posedge CK) begin
    and_p1 <= &dut_in_b;
    and_p2 <= and_p1;
  end
  assign dut_out_b = and_p2;

  vector_sweep_capture #(.N_IN(3), .N_OUT(1), .SETTLE(4)) u_dut_b (
    .CK(CK), .reset(reset), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .rec_valid(valid_b), .rec_ready(ready_b), .rec_data(data_b),
    .signature(sig_b), .state_dbg(st_b)
  );

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q_a[$];
  logic [3:0] exp_q_b[$];
  int errors = 0;
  int checks = 0;

  // Hand-computed records {v, response}.
  logic [3:0] xor_rec [8] = '{4'b0000, 4'b0011, 4'b0101, 4'b0110,
                              4'b1001, 4'b1010, 4'b1100, 4'b1111};
  logic [3:0] and_rec [8] = '{4'b0000, 4'b0010, 4'b0100, 4'b0110,
                              4'b1000, 4'b1010, 4'b1100, 4'b1111};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] misr_model(input logic [15:0] s,
                                             input logic [15:0] d);
    logic [15:0] n;
    n = s << 1;
    if (s[15]) n = n ^ 16'h1021;
    return n ^ d;
  endfunction

  // ---------------- monitors ----------------
  logic chk_period_a = 1'b0;
  int   last_hs_a = 0, last_hs_b = 0;
  logic pend_a = 1'b0, pend_b = 1'b0;
  logic [3:0] e_a, e_b;

  always @(negedge CK) begin
    check("done_a_timing", done_a, pend_a);
    pend_a = 1'b0;
    if (valid_a && ready_a) begin
      if (exp_q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL rec_a_unexpected: got %0h, required no record", data_a);
      end else begin
        e_a = exp_q_a.pop_front();
        check("rec_a", data_a, e_a);
      end
      if (chk_period_a && data_a[3:1] != 3'd0) check("period_a", cyc - last_hs_a, 2);
      last_hs_a = cyc;
      pend_a = (data_a[3:1] == 3'b111);
    end
  end

  always @(negedge CK) begin
    check("done_b_timing", done_b, pend_b);
    pend_b = 1'b0;
    if (valid_b && ready_b) begin
      if (exp_q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL rec_b_unexpected: got %0h, required no record", data_b);
      end else begin
        e_b = exp_q_b.pop_front();
        check("rec_b", data_b, e_b);
      end
      if (data_b[3:1] != 3'd0) check("period_b", cyc - last_hs_b, 5);
      last_hs_b = cyc;
      pend_b = (data_b[3:1] == 3'b111);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic push_a(input int n, input bit flip, output logic [15:0] sig_full,
                        output logic [15:0] sig_part);
    logic [3:0]  r;
    logic [15:0] s;
    s = 16'hFFFF;
    sig_part = 16'hFFFF;
    for (int v = 0; v < 8; v++) begin
      r = xor_rec[v];
      if (flip && v == 5) r = r ^ 4'b0001;
      if (v < n) exp_q_a.push_back(r);
      s = misr_model(s, {12'h000, r});
      if (v == n - 1) sig_part = s;
    end
    sig_full = s;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a();
    bit found;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done_a) begin found = 1; break; end
    end
    check("done_a_seen", found, 1);
    tick();
  endtask

  task automatic wait_dut_in_a(input logic [2:0] v);
    bit found;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy_a && dut_in_a == v) begin found = 1; break; end
      tick();
    end
    check("wait_dut_in_a", found, 1);
  endtask

  task automatic wait_valid_a();
    bit found;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid_a) begin found = 1; break; end
      tick();
    end
    check("wait_valid_a", found, 1);
  endtask

  task automatic check_sig_a(input string name, input logic [15:0] model);
`ifdef VSC_SIGNATURE_EN
    check(name, sig_a, model);
`else
    check(name, sig_a, (model & 16'h0000));
`endif
  endtask

  task automatic check_a_cleared(input string tag);
    check({tag, "_busy"},  busy_a, 0);
    check({tag, "_done"},  done_a, 0);
    check({tag, "_valid"}, valid_a, 0);
    check({tag, "_dut_in"}, dut_in_a, 0);
    check({tag, "_state"}, 32'(st_a), 0);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] sig_ok, sig_part, sig_flip, sig_dummy;

  initial begin
    int n;
    bit found;

    // Reset values
    #23;
    check_a_cleared("reset_a");
    check("reset_a_data", data_a, 0);
    check("reset_a_sig", sig_a, 16'h0000);
    check("reset_b_busy", busy_b, 0);
    check("reset_b_valid", valid_b, 0);
    check("reset_b_sig", sig_b, 16'h0000);
    check("reset_b_state", 32'(st_b), 0);
    @(posedge CK); #1;
    reset = 1'b1;
    tick();

    // Basic sweep, sustained ready
    chk_period_a = 1'b1;
    push_a(8, 0, sig_ok, sig_dummy);
    pulse_start_a();
    check("start_a_busy", busy_a, 1);
    check("start_a_dut_in", dut_in_a, 0);
    wait_done_a();
    chk_period_a = 1'b0;
    check("basic_a_idle", busy_a, 0);
    check("basic_a_queue", exp_q_a.size(), 0);
    check_sig_a("basic_a_sig", sig_ok);

    // Backpressure on record 3
    push_a(8, 0, sig_ok, sig_dummy);
    pulse_start_a();
    wait_dut_in_a(3'd3);
    ready_a = 1'b0;
    wait_valid_a();
    for (int i = 0; i < 5; i++) begin
      check("stall_data", data_a, 4'b0110);
      check("stall_dut_in", dut_in_a, 3'b011);
      check("stall_valid", valid_a, 1);
      tick();
    end
    ready_a = 1'b1;
    wait_done_a();
    check("stall_a_queue", exp_q_a.size(), 0);
    check_sig_a("second_a_sig", sig_ok);

    // Settle on the registered AND DUT
    for (int v = 0; v < 8; v++) exp_q_b.push_back(and_rec[v]);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("start_b_busy", busy_b, 1);
    check("start_b_dut_in", dut_in_b, 0);
    n = 0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (valid_b) begin found = 1; break; end
    end
    check("settle_b_found", found, 1);
    check("settle_b_latency", n, 4);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done_b) begin found = 1; break; end
    end
    check("done_b_seen", found, 1);
    tick();
    check("settle_b_queue", exp_q_b.size(), 0);
    check("settle_b_idle", busy_b, 0);

    // Abort during vector 5 settle
    push_a(5, 0, sig_dummy, sig_part);
    pulse_start_a();
    wait_dut_in_a(3'd5);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check_a_cleared("abort_a");
    check("abort_a_queue", exp_q_a.size(), 0);
    tick(); tick();
    check("abort_a_no_valid", valid_a, 0);
    check_sig_a("abort_a_sig_frozen", sig_part);
    push_a(8, 0, sig_ok, sig_dummy);
    pulse_start_a();
    wait_done_a();
    check("restart_a_queue", exp_q_a.size(), 0);

    // Asynchronous reset while in EMIT
    push_a(3, 0, sig_dummy, sig_dummy);
    pulse_start_a();
    wait_dut_in_a(3'd3);
    ready_a = 1'b0;
    wait_valid_a();
    check("pre_reset_state", 32'(st_a), 2);
    #2 reset = 1'b0;
    #1;
    check_a_cleared("async_reset_a");
    check("async_reset_a_data", data_a, 0);
    check("async_reset_a_sig", sig_a, 16'h0000);
    check("async_reset_a_queue", exp_q_a.size(), 0);
    @(posedge CK); #1;
    reset = 1'b1;
    ready_a = 1'b1;
    tick();
    push_a(8, 0, sig_ok, sig_dummy);
    pulse_start_a();
    wait_done_a();
    check("post_reset_a_queue", exp_q_a.size(), 0);
    check_sig_a("post_reset_a_sig", sig_ok);

`ifdef VSC_SIGNATURE_EN
    // One flipped response must change the signature
    flip_en = 1'b1;
    push_a(8, 1, sig_flip, sig_dummy);
    pulse_start_a();
    wait_done_a();
    flip_en = 1'b0;
    check("flip_a_sig", sig_a, sig_flip);
    check("flip_a_sig_differs", (sig_a != sig_ok), 1);
    check("flip_a_queue", exp_q_a.size(), 0);
`endif

    tick(); tick();
    check("final_a_queue", exp_q_a.size(), 0);
    check("final_b_queue", exp_q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation exceeded time bound");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
